// File: rtl/wb_arbiter_if.sv
// Bus bundle for the writeback arbiter: two result sources in, one
// registered register-file write port out.
interface wb_arbiter_if;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        alu_ready;
  logic        mdu_valid;
  logic [4:0]  mdu_rd;
  logic [31:0] mdu_data;
  logic        mdu_ready;
  logic        reg_write;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic        busy;
  logic [7:0]  drop_count;

  // Handshake: a source transfer happens on a rising clk edge where
  // valid && ready; ready depends only on arbiter state, never on valid.
  modport slave (
    input  alu_valid, alu_rd, alu_data, mdu_valid, mdu_rd, mdu_data,
    output alu_ready, mdu_ready, reg_write, write_reg, write_data, busy,
    output drop_count
  );

  modport master (
    output alu_valid, alu_rd, alu_data, mdu_valid, mdu_rd, mdu_data,
    input  alu_ready, mdu_ready, reg_write, write_reg, write_data, busy,
    input  drop_count
  );
endinterface

// File: rtl/wb_arbiter.sv
// Writeback arbiter: one holding register per source, age/round-robin
// grant into a registered register-file write port, x0 writes dropped.
module wb_arbiter (
  input  logic         clk,
  input  logic         reset,
  wb_arbiter_if.slave  bus
);

  typedef struct packed {
    logic        valid;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        older;
  } hold_t;

  hold_t       alu_q;
  hold_t       mdu_q;
  logic        mdu_last;
  logic        reg_write_q;
  logic [4:0]  write_reg_q;
  logic [31:0] write_data_q;
  logic [7:0]  drop_count_q;

  logic        alu_xfer;
  logic        mdu_xfer;
  logic        alu_load;
  logic        mdu_load;
  logic        alu_drop;
  logic        mdu_drop;
  logic        grant_alu;
  logic        grant_mdu;
  logic        rr_update;
  logic        alu_stays;
  logic        mdu_stays;
  logic [8:0]  drop_sum;

  assign bus.alu_ready  = !alu_q.valid;
  assign bus.mdu_ready  = !mdu_q.valid;
  assign bus.reg_write  = reg_write_q;
  assign bus.write_reg  = write_reg_q;
  assign bus.write_data = write_data_q;
  assign bus.drop_count = drop_count_q;
  assign bus.busy       = alu_q.valid | mdu_q.valid | reg_write_q;

  assign alu_xfer = bus.alu_valid && !alu_q.valid;
  assign mdu_xfer = bus.mdu_valid && !mdu_q.valid;
  assign alu_load = alu_xfer && (bus.alu_rd != 5'd0);
  assign mdu_load = mdu_xfer && (bus.mdu_rd != 5'd0);
  assign alu_drop = alu_xfer && (bus.alu_rd == 5'd0);
  assign mdu_drop = mdu_xfer && (bus.mdu_rd == 5'd0);

  // Same-rd contention is settled by age so writes land in acceptance
  // order; only different-rd contention consults the round-robin pointer.
  always_comb begin
    grant_alu = 1'b0;
    grant_mdu = 1'b0;
    rr_update = 1'b0;
    if (alu_q.valid && mdu_q.valid) begin
      if (alu_q.rd == mdu_q.rd) begin
        grant_alu = alu_q.older;
      end else begin
        grant_alu = mdu_last;
        rr_update = 1'b1;
      end
      grant_mdu = !grant_alu;
    end else begin
      grant_alu = alu_q.valid;
      grant_mdu = mdu_q.valid;
    end
  end

  assign alu_stays = alu_q.valid && !grant_alu;
  assign mdu_stays = mdu_q.valid && !grant_mdu;
  assign drop_sum  = {1'b0, drop_count_q} + {8'd0, alu_drop} + {8'd0, mdu_drop};

  // A new entry is older when the other slot is empty after this edge;
  // on simultaneous loads the ALU entry is the older one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_q        <= '0;
      mdu_q        <= '0;
      mdu_last     <= 1'b1;
      reg_write_q  <= 1'b0;
      write_reg_q  <= 5'd0;
      write_data_q <= 32'd0;
      drop_count_q <= 8'd0;
    end else begin
      if (grant_alu) begin
        alu_q.valid <= 1'b0;
        alu_q.older <= 1'b0;
      end else if (alu_load) begin
        alu_q.valid <= 1'b1;
        alu_q.rd    <= bus.alu_rd;
        alu_q.data  <= bus.alu_data;
        alu_q.older <= !mdu_stays;
      end else if (grant_mdu && alu_q.valid) begin
        alu_q.older <= 1'b1;
      end

      if (grant_mdu) begin
        mdu_q.valid <= 1'b0;
        mdu_q.older <= 1'b0;
      end else if (mdu_load) begin
        mdu_q.valid <= 1'b1;
        mdu_q.rd    <= bus.mdu_rd;
        mdu_q.data  <= bus.mdu_data;
        mdu_q.older <= !(alu_stays || alu_load);
      end else if (grant_alu && mdu_q.valid) begin
        mdu_q.older <= 1'b1;
      end

      if (rr_update) begin
        mdu_last <= grant_mdu;
      end

      reg_write_q <= grant_alu || grant_mdu;
      if (grant_alu) begin
        write_reg_q  <= alu_q.rd;
        write_data_q <= alu_q.data;
      end else if (grant_mdu) begin
        write_reg_q  <= mdu_q.rd;
        write_data_q <= mdu_q.data;
      end

      drop_count_q <= drop_sum[8] ? 8'hff : drop_sum[7:0];
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: expected writes are queued as stimulus is
// driven and checked in order by a monitor on the falling clock edge.
module tb_wb_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b0;
  wb_arbiter_if bus ();

  wb_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int write_count = 0;
  int wc0;
  logic [36:0] exp_q[$];
  logic [36:0] exp_item;
  logic [31:0] bp_d[4];

  task automatic check(input string tag, input logic [36:0] obs, input logic [36:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_alu(input logic v, input logic [4:0] rd, input logic [31:0] d);
    bus.alu_valid = v;
    bus.alu_rd    = rd;
    bus.alu_data  = d;
  endtask

  task automatic drive_mdu(input logic v, input logic [4:0] rd, input logic [31:0] d);
    bus.mdu_valid = v;
    bus.mdu_rd    = rd;
    bus.mdu_data  = d;
  endtask

  task automatic idle();
    drive_alu(1'b0, 5'd0, 32'd0);
    drive_mdu(1'b0, 5'd0, 32'd0);
  endtask

  task automatic expect_write(input logic [4:0] rd, input logic [31:0] d);
    exp_q.push_back({rd, d});
  endtask

  // Scoreboard monitor: every register-file write must match the queue head.
  always @(negedge clk) begin
    if (bus.reg_write === 1'b1) begin
      write_count++;
      check("write_reg_nonzero", 37'(bus.write_reg != 5'd0), 37'd1);
      check("write_expected", 37'(exp_q.size() != 0), 37'd1);
      if (exp_q.size() != 0) begin
        exp_item = exp_q.pop_front();
        check("write_order", {bus.write_reg, bus.write_data}, exp_item);
      end
    end
  end

  initial begin
    idle();
    #1 reset = 1'b1;
    #1;
    check("rst_reg_write", 37'(bus.reg_write), 37'd0);
    check("rst_write_reg", 37'(bus.write_reg), 37'd0);
    check("rst_write_data", 37'(bus.write_data), 37'd0);
    check("rst_drop", 37'(bus.drop_count), 37'd0);
    check("rst_alu_ready", 37'(bus.alu_ready), 37'd1);
    check("rst_mdu_ready", 37'(bus.mdu_ready), 37'd1);
    check("rst_busy", 37'(bus.busy), 37'd0);
    step();
    step();
    reset = 1'b0;

    // Single write: two-edge latency, one-cycle pulse.
    drive_alu(1'b1, 5'd5, 32'hDEADBEEF);
    expect_write(5'd5, 32'hDEADBEEF);
    step();
    idle();
    check("single_alu_ready_low", 37'(bus.alu_ready), 37'd0);
    check("single_no_write_yet", 37'(bus.reg_write), 37'd0);
    step();
    check("single_reg_write", 37'(bus.reg_write), 37'd1);
    check("single_data", {bus.write_reg, bus.write_data}, {5'd5, 32'hDEADBEEF});
    check("single_alu_ready_back", 37'(bus.alu_ready), 37'd1);
    step();
    check("single_write_drop", 37'(bus.reg_write), 37'd0);
    check("single_hold_reg", 37'(bus.write_reg), 37'd5);
    check("single_idle_busy", 37'(bus.busy), 37'd0);

    // Different-rd tie after reset: ALU first.
    drive_alu(1'b1, 5'd3, 32'h33);
    drive_mdu(1'b1, 5'd4, 32'h44);
    expect_write(5'd3, 32'h33);
    expect_write(5'd4, 32'h44);
    step();
    idle();
    step();
    check("tie1_first", 37'(bus.write_reg), 37'd3);
    check("tie1_mdu_waiting", 37'(bus.mdu_ready), 37'd0);
    step();
    check("tie1_second", 37'(bus.write_reg), 37'd4);
    step();

    // Simultaneous same rd: ALU then MDU even though round-robin favours MDU.
    drive_alu(1'b1, 5'd8, 32'hA);
    drive_mdu(1'b1, 5'd8, 32'hB);
    expect_write(5'd8, 32'hA);
    expect_write(5'd8, 32'hB);
    step();
    idle();
    step();
    check("same_rd_first", 37'(bus.write_data), 37'hA);
    step();
    check("same_rd_second", 37'(bus.write_data), 37'hB);
    step();

    // Repeat different-rd tie: MDU now wins.
    drive_alu(1'b1, 5'd3, 32'h133);
    drive_mdu(1'b1, 5'd4, 32'h144);
    expect_write(5'd4, 32'h144);
    expect_write(5'd3, 32'h133);
    step();
    idle();
    step();
    check("tie2_first", 37'(bus.write_reg), 37'd4);
    step();
    check("tie2_second", 37'(bus.write_reg), 37'd3);
    step();

    // MDU then ALU to the same rd on consecutive edges.
    drive_mdu(1'b1, 5'd7, 32'd1);
    expect_write(5'd7, 32'd1);
    expect_write(5'd7, 32'd2);
    step();
    drive_mdu(1'b0, 5'd0, 32'd0);
    drive_alu(1'b1, 5'd7, 32'd2);
    step();
    idle();
    check("order_first", {bus.write_reg, bus.write_data}, {5'd7, 32'd1});
    step();
    check("order_second", {bus.write_reg, bus.write_data}, {5'd7, 32'd2});
    step();

    // x0 drops: double drop, then saturation.
    wc0 = write_count;
    drive_alu(1'b1, 5'd0, $urandom());
    drive_mdu(1'b1, 5'd0, $urandom());
    step();
    drive_mdu(1'b0, 5'd0, 32'd0);
    check("drop_double", 37'(bus.drop_count), 37'd2);
    check("drop_alu_ready", 37'(bus.alu_ready), 37'd1);
    for (int i = 0; i < 300; i++) begin
      drive_alu(1'b1, 5'd0, $urandom());
      step();
      if (i == 9) check("drop_mid", 37'(bus.drop_count), 37'd12);
    end
    idle();
    step();
    check("drop_saturated", 37'(bus.drop_count), 37'd255);
    check("drop_no_writes", 37'(write_count - wc0), 37'd0);

    // Backpressure: MDU valid held for four edges, only two accepted.
    for (int i = 0; i < 4; i++) bp_d[i] = $urandom();
    wc0 = write_count;
    expect_write(5'd9, bp_d[0]);
    expect_write(5'd9, bp_d[2]);
    for (int i = 0; i < 4; i++) begin
      drive_mdu(1'b1, 5'd9, bp_d[i]);
      step();
      check("bp_mdu_ready", 37'(bus.mdu_ready), 37'(i % 2));
    end
    idle();
    step();
    step();
    check("bp_write_count", 37'(write_count - wc0), 37'd2);

    // Reset with both entries pending: no write, readies restored at once.
    wc0 = write_count;
    drive_alu(1'b1, 5'd20, 32'h20);
    drive_mdu(1'b1, 5'd21, 32'h21);
    step();
    idle();
    check("pend_busy", 37'(bus.busy), 37'd1);
    check("pend_readies", 37'({bus.alu_ready, bus.mdu_ready}), 37'd0);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_reg_write", 37'(bus.reg_write), 37'd0);
    check("mid_rst_readies", 37'({bus.alu_ready, bus.mdu_ready}), 37'd3);
    check("mid_rst_busy", 37'(bus.busy), 37'd0);
    check("mid_rst_drop", 37'(bus.drop_count), 37'd0);
    step();
    step();
    reset = 1'b0;
    step();
    step();
    step();
    check("post_rst_reg_write", 37'(bus.reg_write), 37'd0);
    check("post_rst_no_writes", 37'(write_count - wc0), 37'd0);
    check("queue_drained", 37'(exp_q.size()), 37'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
